// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: data widths,
// starvation counter width, FSM state encoding and grant encoding.
package mem_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int BE_W     = 4;
  localparam int STARVE_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY_I = 2'b01,
    BUSY_D = 2'b10,
    ACK    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_I    = 2'b01,
    GRANT_D    = 2'b10
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection. Data wins a tie unless the instruction side
// has already been passed over STARVE_MAX times in a row.
import mem_arbiter_pkg::*;

module mem_arb_pick #(
  parameter int STARVE_MAX = 4
) (
  input  logic                i_req,
  input  logic                d_req,
  input  logic [STARVE_W-1:0] starve_cnt,
  output grant_t              grant
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  // Pick the next owner from the pending requests and the starvation count
  always_comb begin
    grant = GRANT_NONE;
    if (i_req && d_req) begin
      if (starve_cnt == STARVE_LIM) begin
        grant = GRANT_I;
      end else begin
        grant = GRANT_D;
      end
    end else if (i_req) begin
      grant = GRANT_I;
    end else if (d_req) begin
      grant = GRANT_D;
    end else begin
      grant = GRANT_NONE;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of a single memory port.
// One access in flight at a time; all outputs are registered.
import mem_arbiter_pkg::*;

module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_req,
  input  logic [XLEN-1:0] i_addr,
  output logic [XLEN-1:0] i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [BE_W-1:0] d_be,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_valid
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  state_t              state;
  state_t              state_nxt;
  grant_t              grant;
  logic [STARVE_W-1:0] starve_cnt;
  logic                idle_grant_i;
  logic                idle_grant_d;
  logic                done_i;
  logic                done_d;

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .i_req      (i_req),
    .d_req      (d_req),
    .starve_cnt (starve_cnt),
    .grant      (grant)
  );

  // Grants only take effect from IDLE; completions only count while busy,
  // so a stray mem_valid elsewhere has no effect
  always_comb begin
    idle_grant_i = (state == IDLE) && (grant == GRANT_I);
    idle_grant_d = (state == IDLE) && (grant == GRANT_D);
    done_i       = (state == BUSY_I) && mem_valid;
    done_d       = (state == BUSY_D) && mem_valid;
  end

  // Next-state logic for the access FSM
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant == GRANT_I) begin
          state_nxt = BUSY_I;
        end else if (grant == GRANT_D) begin
          state_nxt = BUSY_D;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_valid) begin
          state_nxt = ACK;
        end else begin
          state_nxt = state;
        end
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Count data grants that bypass a waiting fetch; any fetch grant clears it
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= {STARVE_W{1'b0}};
    end else if (idle_grant_i) begin
      starve_cnt <= {STARVE_W{1'b0}};
    end else if (idle_grant_d && i_req && (starve_cnt < STARVE_LIM)) begin
      starve_cnt <= starve_cnt + {{(STARVE_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt <= starve_cnt;
    end
  end

  // Memory request is high exactly while the FSM will be in a busy state
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req <= 1'b0;
    end else begin
      mem_req <= (state_nxt == BUSY_I) || (state_nxt == BUSY_D);
    end
  end

  // Latch the winner's access attributes at grant; held until the next grant
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_be    <= {BE_W{1'b0}};
      mem_addr  <= {XLEN{1'b0}};
      mem_wdata <= {XLEN{1'b0}};
    end else if (idle_grant_i) begin
      mem_we    <= 1'b0;
      mem_be    <= {BE_W{1'b1}};
      mem_addr  <= i_addr;
      mem_wdata <= {XLEN{1'b0}};
    end else if (idle_grant_d) begin
      mem_we    <= d_we;
      mem_be    <= d_be;
      mem_addr  <= d_addr;
      mem_wdata <= d_wdata;
    end else begin
      mem_we    <= mem_we;
      mem_be    <= mem_be;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
    end
  end

  // Completion pulses: set on the completing edge, so they live in ACK only
  always_ff @(posedge clk) begin
    if (reset) begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
    end else begin
      i_ack <= done_i;
      d_ack <= done_d;
    end
  end

  // Read data capture: fetches always, data side only for loads
  always_ff @(posedge clk) begin
    if (reset) begin
      i_rdata <= {XLEN{1'b0}};
      d_rdata <= {XLEN{1'b0}};
    end else begin
      if (done_i) begin
        i_rdata <= mem_rdata;
      end else begin
        i_rdata <= i_rdata;
      end
      if (done_d && !mem_we) begin
        d_rdata <= mem_rdata;
      end else begin
        d_rdata <= d_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a monitor pops and compares them whenever an ack appears.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_valid;

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
  } exp_t;

  exp_t q[$];
  int   n_total;
  int   n_pass;
  int   lat;
  int   mcnt;
  logic spur;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_be      (d_be),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_valid (mem_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers after `lat` request cycles with addr + 0x83;
  // with no request it can drive a spurious valid carrying junk data.
  initial begin
    mem_valid = 1'b0;
    mem_rdata = 32'h0;
    mcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req) begin
        mcnt = mcnt + 1;
        if (mcnt >= lat) begin
          mem_valid = 1'b1;
          mem_rdata = mem_addr + 32'h0000_0083;
          mcnt = 0;
        end else begin
          mem_valid = 1'b0;
        end
      end else begin
        mcnt = 0;
        mem_valid = spur;
        mem_rdata = spur ? 32'hDEAD_BEEF : 32'h0;
      end
    end
  end

  // Monitor: every ack must match the oldest expected completion
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (i_ack && d_ack) begin
        check("dual_ack", {i_ack, d_ack}, 2'b01);
      end else if (i_ack || d_ack) begin
        if (q.size() == 0) begin
          check("unexpected_ack", {i_ack, d_ack}, 2'b00);
        end else begin
          e = q.pop_front();
          check("ack_owner", d_ack, e.is_d);
          if (e.is_d) begin
            check("d_rdata", d_rdata, e.rdata);
          end else begin
            check("i_rdata", i_rdata, e.rdata);
          end
        end
      end
    end
  end

  task automatic push_exp(input logic is_d, input logic [31:0] rdata);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    q.push_back(e);
  endtask

  // Wait (bounded) for an ack; when exp_n > 0 also check the negedge count
  task automatic wait_ack(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(i_ack || d_ack) && n < 40);
    check({name, "_ack_seen"}, i_ack | d_ack, 1'b1);
    if (exp_n > 0) begin
      check({name, "_latency"}, n, exp_n);
    end
  endtask

  // Wait (bounded) for mem_req, then check the granted address
  task automatic wait_grant(input string name, input logic [31:0] exp_addr);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 40);
    check({name, "_grant_addr"}, {mem_req, mem_addr}, {1'b1, exp_addr});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    n_total = 0;
    n_pass  = 0;
    lat     = 1;
    spur    = 1'b0;
    reset   = 1'b1;
    i_req   = 1'b0;
    i_addr  = 32'h0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_be    = 4'h0;
    d_addr  = 32'h0;
    d_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {mem_req, i_ack, d_ack, i_rdata, d_rdata},
          {1'b0, 1'b0, 1'b0, 32'h0, 32'h0});
    reset = 1'b0;
    @(negedge clk);

    // Single fetch, memory latency 1
    i_req  = 1'b1;
    i_addr = 32'h0000_0010;
    push_exp(1'b0, 32'h0000_0093);
    @(negedge clk);
    check("fetch_attr", {mem_req, mem_we, mem_be, mem_addr},
          {1'b1, 1'b0, 4'b1111, 32'h0000_0010});
    wait_ack("fetch", 1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Simultaneous: data first, fetch after ack plus one idle cycle
    i_req  = 1'b1;
    i_addr = 32'h0000_0020;
    d_req  = 1'b1;
    d_we   = 1'b0;
    d_be   = 4'b1111;
    d_addr = 32'h0000_0100;
    push_exp(1'b1, 32'h0000_0183);
    @(negedge clk);
    check("simul_first", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 32'h0000_0100});
    wait_ack("simul_load", 1);
    d_req = 1'b0;
    push_exp(1'b0, 32'h0000_00A3);
    @(negedge clk);
    check("simul_idle_gap", mem_req, 1'b0);
    @(negedge clk);
    check("simul_second", {mem_req, mem_we, mem_be, mem_addr},
          {1'b1, 1'b0, 4'b1111, 32'h0000_0020});
    wait_ack("simul_fetch", 1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Starvation: both held -> four data grants, then the fetch
    i_req  = 1'b1;
    i_addr = 32'h0000_0040;
    d_req  = 1'b1;
    d_addr = 32'h0000_0200;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) begin
        wait_grant("starve_d", 32'h0000_0200);
        push_exp(1'b1, 32'h0000_0283);
      end else begin
        wait_grant("starve_i", 32'h0000_0040);
        push_exp(1'b0, 32'h0000_00C3);
      end
      wait_ack("starve", 1);
    end
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    // Counter must be cleared: a fresh tie goes to data again
    i_req = 1'b1;
    d_req = 1'b1;
    wait_grant("starve_cleared", 32'h0000_0200);
    push_exp(1'b1, 32'h0000_0283);
    wait_ack("cleared_load", 1);
    d_req = 1'b0;
    wait_grant("cleared_fetch", 32'h0000_0040);
    push_exp(1'b0, 32'h0000_00C3);
    wait_ack("cleared_fetch", 1);
    i_req = 1'b0;
    repeat (2) @(negedge clk);

    // Store with latency 5: attributes stable, single ack, d_rdata kept
    lat     = 5;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_be    = 4'b0100;
    d_addr  = 32'h0000_0300;
    d_wdata = 32'h00AB_0000;
    push_exp(1'b1, 32'h0000_0283);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("store_stable", {mem_req, mem_we, mem_be, mem_addr, mem_wdata, d_ack},
            {1'b1, 1'b1, 4'b0100, 32'h0000_0300, 32'h00AB_0000, 1'b0});
    end
    @(negedge clk);
    check("store_ack", {d_ack, mem_req}, 2'b10);
    d_req = 1'b0;
    d_we  = 1'b0;
    @(negedge clk);
    check("store_ack_once", d_ack, 1'b0);

    // Spurious mem_valid while idle with no requests
    spur = 1'b1;
    repeat (3) @(negedge clk);
    check("spur_idle", {i_ack, d_ack, mem_req, i_rdata, d_rdata},
          {1'b0, 1'b0, 1'b0, 32'h0000_00C3, 32'h0000_0283});
    spur = 1'b0;
    @(negedge clk);

    // Reset in the second BUSY_D cycle of a latency-4 load
    lat    = 4;
    d_req  = 1'b1;
    d_be   = 4'b1111;
    d_addr = 32'h0000_0400;
    @(negedge clk);
    check("abort_busy", mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_reset", {mem_req, d_ack, i_rdata, d_rdata},
          {1'b0, 1'b0, 32'h0, 32'h0});
    reset = 1'b0;
    d_req = 1'b0;
    spur  = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_stray", {mem_req, i_ack, d_ack, d_rdata}, {1'b0, 1'b0, 1'b0, 32'h0});
    spur = 1'b0;
    @(negedge clk);

    // Back in IDLE: a fetch must see minimum latency
    lat    = 1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0050;
    push_exp(1'b0, 32'h0000_00D3);
    wait_ack("post_reset_fetch", 2);
    i_req = 1'b0;
    repeat (3) @(negedge clk);

    check("scoreboard_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4: maximum consecutive data grants while an instruction request waits.
REQ-002 Port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port i_req, input, 1: instruction-fetch request, held until i_ack.
REQ-005 Port i_addr, input, 32: fetch byte address.
REQ-006 Port i_rdata, output, 32: fetched instruction word.
REQ-007 Port i_ack, output, 1: one-cycle fetch completion pulse.
REQ-008 Port d_req, input, 1: load/store request, held until d_ack.
REQ-009 Port d_we, input, 1: 1 = store, 0 = load.
REQ-010 Port d_be, input, 4: byte enables.
REQ-011 Port d_addr, input, 32: data byte address.
REQ-012 Port d_wdata, input, 32: store data, lane-aligned.
REQ-013 Port d_rdata, output, 32: load data word.
REQ-014 Port d_ack, output, 1: one-cycle data completion pulse.
REQ-015 Port mem_req, output, 1: memory access active; held until mem_valid.
REQ-016 Port mem_we, mem_be, mem_addr, mem_wdata, outputs, 1/4/32/32: registered access attributes.
REQ-017 Port mem_rdata, input, 32; port mem_valid, input, 1: memory completion, any latency >= 1 cycle.

Function
REQ-018 FSM states IDLE, BUSY_I, BUSY_D, ACK; reset state IDLE.
REQ-019 IDLE, neither request: stay IDLE, mem_req=0.
REQ-020 IDLE, one request: grant it next cycle (BUSY_I or BUSY_D).
REQ-021 IDLE, both requests: grant data unless starve_cnt==STARVE_MAX, then grant instruction.
REQ-022 On grant, capture the owner's address/we/be/wdata into mem_* registers; fetch forces mem_we=0, mem_be=4'b1111.
REQ-023 mem_req=1 throughout BUSY_I/BUSY_D; mem_* stable until mem_valid.
REQ-024 BUSY_x with mem_valid=1: register mem_rdata, go ACK, mem_req=0 in the next cycle.
REQ-025 ACK: pulse the owner's ack exactly one cycle; next state IDLE regardless of inputs.
REQ-026 i_rdata updates only on fetch completion; d_rdata updates only on load completion; stores leave d_rdata unchanged.
REQ-027 Minimum latency: request sampled in IDLE at edge N -> mem_req from N+1 -> mem_valid at N+1 -> ack at N+2; the next grant is no earlier than N+3.
REQ-028 starve_cnt, 3-bit saturating at STARVE_MAX: +1 on a data grant while i_req=1; cleared on any instruction grant; unchanged otherwise.
REQ-029 mem_valid outside BUSY_I/BUSY_D is ignored.
REQ-030 Request deassertion during BUSY_x does not abort the access; completion still pulses ack.
REQ-031 Never more than one ack asserted in a cycle; never two transactions outstanding.

Reset
REQ-032 reset=1 at any edge: state IDLE, starve_cnt=0, all outputs 0 including mem_req, i_rdata, d_rdata.
REQ-033 Reset mid-transaction aborts it silently: no ack issued; a late mem_valid is ignored.

Structure
REQ-034 Shared package holds the FSM state encoding, XLEN=32 and the byte-enable width of 4.
REQ-035 One combinational sub-module, mem_arb_pick, computes the grant from i_req, d_req, starve_cnt and STARVE_MAX; everything else lives in mem_arbiter.

Verification
REQ-036 Single fetch: i_req, i_addr=0x0000_0010, mem_valid after 1 cycle with 0x0000_0093 -> i_ack one cycle, i_rdata=0x0000_0093, mem_we=0, mem_be=1111.
REQ-037 Simultaneous: i_req=d_req=1, load d_addr=0x100 -> data granted first (mem_addr=0x100); fetch granted after d_ack plus one IDLE cycle.
REQ-038 Starvation: i_req held, d_req held, STARVE_MAX=4 -> exactly 4 data grants, 5th grant is fetch, starve_cnt=0 afterwards.
REQ-039 Store: d_we=1, d_be=0100, d_wdata=0x00AB_0000, mem latency 5 -> mem_* stable for 5 cycles, d_ack once, d_rdata unchanged.
REQ-040 Reset at the 2nd cycle of BUSY_D with latency 4 -> mem_req=0 next cycle, no d_ack, state IDLE, stray mem_valid ignored.
REQ-041 Spurious mem_valid=1 while IDLE with no requests -> no ack, no rdata change.
